// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, FSM state type and field-width helpers for multicycle_cpu
// Purpose: common definitions imported by multicycle_cpu and cpu_alu.
// Ports: none (package).
package cpu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_LDI = 3'b100;
  localparam logic [2:0] OP_LD  = 3'b101;
  localparam logic [2:0] OP_ST  = 3'b110;
  // 3'b111 is BZ, or HALT when rd is all ones.
  localparam logic [2:0] OP_BZ  = 3'b111;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } state_t;

  // A single-register file still needs a one-bit index field to stay legal.
  function automatic int ridx_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  function automatic int instr_width(input int nregs, input int imm_w);
    return 3 + ridx_width(nregs) + imm_w;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational ALU producing result, zero and carry/borrow
// Purpose: ADD/SUB/AND/OR datapath for multicycle_cpu.
// Ports: a, b (operands, DATA_W), op (opcode, 3) -> result (DATA_W), z (result==0),
//        c (carry-out for ADD, borrow for SUB, 0 otherwise).
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide = '0;
    c    = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        c    = wide[DATA_W];
      end
      OP_SUB: begin
        // The extra top bit of an unsigned subtract is set exactly when a < b.
        wide = {1'b0, a} - {1'b0, b};
        c    = wide[DATA_W];
      end
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      default: wide = '0;
    endcase
    result = wide[DATA_W-1:0];
    z      = (result == '0);
  end

endmodule

// File: rtl/multicycle_cpu.sv
// rtl/multicycle_cpu.sv - multi-cycle CPU with FETCH/EXEC/MEM/HALT FSM and req/valid memories
// Purpose: fetch and execute one instruction at a time, tolerating memory wait states.
// Ports: clk, reset (sync, active-high);
//        imem_req/imem_addr out, imem_valid/imem_rdata in (instruction fetch);
//        dmem_req/dmem_we/dmem_addr/dmem_wdata out, dmem_valid/dmem_rdata in (data access);
//        alu_result (last register write), pc_out, retired (pulse per instruction), halted.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREGS  = 4,
  parameter int IMM_W  = 3,
  localparam int RIDX_W  = ridx_width(NREGS),
  localparam int INSTR_W = instr_width(NREGS, IMM_W)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_valid,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [DATA_W-1:0]  alu_result,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               retired,
  output logic               halted
);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]    regs_q [NREGS];
  logic [DATA_W-1:0]    regs_d [NREGS];
  logic                 z_q, z_d;
  logic                 c_q, c_d;
  logic [DATA_W-1:0]    alu_result_q, alu_result_d;

  logic [2:0]           opcode;
  logic [RIDX_W-1:0]    rd;
  logic [RIDX_W-1:0]    rs;
  logic [IMM_W-1:0]     imm;
  logic                 is_halt;

  logic [DATA_W-1:0]    alu_res;
  logic                 alu_z;
  logic                 alu_c;
  logic                 wr_en;
  logic [DATA_W-1:0]    wr_data;

  assign opcode  = ir_q[INSTR_W-1 -: 3];
  assign rd      = ir_q[IMM_W +: RIDX_W];
  assign imm     = ir_q[IMM_W-1:0];
  assign rs      = imm[RIDX_W-1:0];
  assign is_halt = (opcode == OP_BZ) && (&rd);

  cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (regs_q[rd]),
    .b      (regs_q[rs]),
    .op     (opcode),
    .result (alu_res),
    .z      (alu_z),
    .c      (alu_c)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    regs_d       = regs_q;
    z_d          = z_q;
    c_d          = c_q;
    alu_result_d = alu_result_q;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    retired      = 1'b0;
    wr_en        = 1'b0;
    wr_data      = '0;

    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            wr_en   = 1'b1;
            wr_data = alu_res;
            z_d     = alu_z;
            c_d     = alu_c;
            retired = 1'b1;
            state_d = FETCH;
          end
          OP_LDI: begin
            wr_en   = 1'b1;
            wr_data = DATA_W'(imm);
            retired = 1'b1;
            state_d = FETCH;
          end
          OP_LD, OP_ST: state_d = MEM;
          default: begin
            retired = 1'b1;
            if (is_halt) begin
              state_d = HALT;
            end else begin
              if (z_q) pc_d = ADDR_W'(imm);
              state_d = FETCH;
            end
          end
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        if (dmem_valid) begin
          retired = 1'b1;
          state_d = FETCH;
          if (opcode == OP_LD) begin
            wr_en   = 1'b1;
            wr_data = dmem_rdata;
          end
        end
      end
      HALT: ;
      default: state_d = FETCH;
    endcase

    if (wr_en) begin
      regs_d[rd]   = wr_data;
      alu_result_d = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= '0;
      ir_q         <= '0;
      z_q          <= 1'b0;
      c_q          <= 1'b0;
      alu_result_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      z_q          <= z_d;
      c_q          <= c_d;
      alu_result_q <= alu_result_d;
      regs_q       <= regs_d;
    end
  end

  // Address, direction and write data come straight from IR/register state,
  // which cannot change while MEM waits, so they stay stable until valid.
  assign imem_addr  = pc_q;
  assign pc_out     = pc_q;
  assign dmem_we    = (opcode == OP_ST);
  assign dmem_addr  = ADDR_W'(imm);
  assign dmem_wdata = regs_q[rd];
  assign alu_result = alu_result_q;
  assign halted     = (state_q == HALT);

endmodule
